booth3_mul_arbiter: RTL and testbench
=====================================

BOOTH3_MUL_ARBITER -- requirements
Module: booth3_mul_arbiter

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits signed and the result width at 16 bits signed.
REQ-002 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high, with the ports named as follows.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 req0_valid, req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-006 req0_ready, req1_ready  output  1 each  requester 0/1 is accepted this cycle.
REQ-007 req0_multiplicand, req0_multiplier, req1_multiplicand, req1_multiplier  input  8 each  two's-complement operands.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer takes the result.
REQ-010 rsp_id  output  1  index of the requester that owns the result.
REQ-011 rsp_result  output  16  signed product.
REQ-012 busy  output  1  state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ITER and DONE.
REQ-014 In IDLE, the arbiter SHALL assert at most one reqN_ready, combinationally, to a valid requester.
- Round-robin: when both requesters are valid, grant the one not granted last.
- last_grant resets to 1, so requester 0 wins the first tie.
REQ-015 An acceptance (valid and ready at a rising edge) SHALL do all of the following at that edge:
- latch multiplicand A and multiplier B;
- latch 3A, computed combinationally from the granted operand;
- latch rsp_id and update last_grant;
- clear the 16-bit accumulator and digit counter;
- go to ITER.
REQ-016 The Booth radix-8 digits SHALL be formed from B extended to 9 bits (b8=b7, b(-1)=0) as d_i = -4*b(3i+2) + 2*b(3i+1) + b(3i) + b(3i-1), for i = 0..2; each d_i lies in -4..+4.
REQ-017 ITER SHALL process one digit per cycle, LSB digit first, adding sign-extended (d_i * A) << 3i to the accumulator modulo 2^16.
- Select ±0, ±A, ±2A, ±3A (latched), ±4A.
- After digit 2, go to DONE.
REQ-018 Latency SHALL be 3 cycles: acceptance at edge E0 -> rsp_valid=1 after edge E3.
REQ-019 In DONE, rsp_valid SHALL be 1, and rsp_result and rsp_id SHALL hold stable until rsp_valid and rsp_ready are both sampled high at an edge; the FSM then goes to IDLE.
REQ-020 The next acceptance SHALL occur no earlier than the edge after the response handshake; both reqN_ready outputs SHALL be 0 outside IDLE.
REQ-021 rsp_ready held high continuously SHALL give a throughput of one operation per 5 cycles.
REQ-022 A requester deasserting valid before it is granted SHALL lose nothing and SHALL not advance last_grant.
REQ-023 The operand pair -128 * -128 SHALL produce +16384; no overflow flag SHALL exist, because every 8x8 signed product fits in 16 bits.
REQ-024 rsp_result SHALL be 0 whenever rsp_valid=0.

Reset
REQ-025 RST=1 SHALL immediately force the following, regardless of the current state:
- state=IDLE, last_grant=1;
- accumulator, operands, digit counter, rsp_id = 0;
- rsp_valid=0, busy=0.
REQ-026 Reset asserted during ITER or DONE SHALL discard the operation silently; no response is ever issued for it.
REQ-027 The first acceptance SHALL be possible at the first rising edge after RST deasserts.

Structure
REQ-028 Shared package booth3_pkg SHALL hold:
- the state encoding;
- OPW=8, RESW=16, NDIGITS=3;
- the digit-select encoding (ZERO, A1, A2, A3, A4 plus negate).
REQ-029 One combinational sub-module, booth3_digit_pp, SHALL be instantiated once. It maps a 4-bit bit-group plus A and 3A to the signed 16-bit partial product before the shift.
REQ-030 The arbiter, FSM, accumulator and shifting SHALL reside in booth3_mul_arbiter.

Verification
REQ-031 Single request, req0: A=0x89, B=0x26, rsp_ready=1 -> rsp_result=0xEE56 (-4522) and rsp_id=0, with rsp_valid exactly 3 cycles after acceptance.
REQ-032 Tie after reset: both requesters valid with A=0x7A, B=0x3F -> req0 served first (0x1E06), then req1, with no cycle in which both ready outputs are high.
REQ-033 Corner operands -> required products:
- 0x80 * 0x80 -> 0x4000;
- 0x05 * 0xFE -> 0xFFF6;
- 0x00 * 0x7F -> 0x0000;
- 0x7F * 0x80 -> 0xC080.
REQ-034 Backpressure: rsp_ready held low for 5 cycles in DONE -> rsp_result and rsp_id stable, both reqN_ready low; the result retires on the first cycle rsp_ready=1.
REQ-035 Reset during ITER (second digit cycle) -> outputs return to reset values asynchronously; the next request, A=0x3F, B=0x3F, returns 0x0F81.
REQ-036 Random soak: 10k operations with random valid/rsp_ready on both requesters -> every result matches the signed-product reference model, and neither requester is starved for more than one consecutive grant while it is valid.

Source files
------------

// File: rtl/booth3_pkg.sv
// Shared definitions for the radix-8 Booth multiplier with two-requester arbiter.
package booth3_pkg;

    localparam int OPW     = 8;
    localparam int RESW    = 16;
    localparam int NDIGITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Magnitude of a Booth radix-8 digit; the sign travels separately.
    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_A1   = 3'd1,
        SEL_A2   = 3'd2,
        SEL_A3   = 3'd3,
        SEL_A4   = 3'd4
    } sel_mag_t;

    typedef struct packed {
        logic     neg;
        sel_mag_t mag;
    } digit_sel_t;

    // Bit group {b(3i+2), b(3i+1), b(3i), b(3i-1)} -> signed digit in -4..+4.
    function automatic digit_sel_t decode_digit(input logic [3:0] grp);
        digit_sel_t sel;
        sel.neg = 1'b0;
        sel.mag = SEL_ZERO;
        case (grp)
            4'b0000: begin sel.neg = 1'b0; sel.mag = SEL_ZERO; end
            4'b0001: begin sel.neg = 1'b0; sel.mag = SEL_A1;   end
            4'b0010: begin sel.neg = 1'b0; sel.mag = SEL_A1;   end
            4'b0011: begin sel.neg = 1'b0; sel.mag = SEL_A2;   end
            4'b0100: begin sel.neg = 1'b0; sel.mag = SEL_A2;   end
            4'b0101: begin sel.neg = 1'b0; sel.mag = SEL_A3;   end
            4'b0110: begin sel.neg = 1'b0; sel.mag = SEL_A3;   end
            4'b0111: begin sel.neg = 1'b0; sel.mag = SEL_A4;   end
            4'b1000: begin sel.neg = 1'b1; sel.mag = SEL_A4;   end
            4'b1001: begin sel.neg = 1'b1; sel.mag = SEL_A3;   end
            4'b1010: begin sel.neg = 1'b1; sel.mag = SEL_A3;   end
            4'b1011: begin sel.neg = 1'b1; sel.mag = SEL_A2;   end
            4'b1100: begin sel.neg = 1'b1; sel.mag = SEL_A2;   end
            4'b1101: begin sel.neg = 1'b1; sel.mag = SEL_A1;   end
            4'b1110: begin sel.neg = 1'b1; sel.mag = SEL_A1;   end
            4'b1111: begin sel.neg = 1'b0; sel.mag = SEL_ZERO; end
            default: begin sel.neg = 1'b0; sel.mag = SEL_ZERO; end
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth3_digit_pp.sv
// Combinational Booth radix-8 partial product: one bit group times A, unshifted.
module booth3_digit_pp
    import booth3_pkg::*;
(
    input  logic [3:0]      grp_i,
    input  logic [OPW-1:0]  a_i,
    input  logic [OPW+1:0]  a3_i,
    output logic [RESW-1:0] pp_o
);

    digit_sel_t      sel_s;
    logic [RESW-1:0] mag_s;

    // Pick the sign-extended multiple of A, then negate if the digit is negative.
    always_comb begin
        sel_s = decode_digit(grp_i);
        case (sel_s.mag)
            SEL_A1:  mag_s = {{8{a_i[7]}}, a_i};
            SEL_A2:  mag_s = {{7{a_i[7]}}, a_i, 1'b0};
            SEL_A3:  mag_s = {{6{a3_i[9]}}, a3_i};
            SEL_A4:  mag_s = {{6{a_i[7]}}, a_i, 2'b00};
            default: mag_s = 16'd0;
        endcase
        if (sel_s.neg) begin
            pp_o = ~mag_s + 16'd1;
        end else begin
            pp_o = mag_s;
        end
    end

endmodule

// File: rtl/booth3_mul_arbiter.sv
// Two-requester round-robin arbiter in front of a 3-cycle radix-8 Booth multiplier.
module booth3_mul_arbiter
    import booth3_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            req0_valid,
    input  logic            req1_valid,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic [OPW-1:0]  req0_multiplicand,
    input  logic [OPW-1:0]  req0_multiplier,
    input  logic [OPW-1:0]  req1_multiplicand,
    input  logic [OPW-1:0]  req1_multiplier,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [RESW-1:0] rsp_result,
    output logic            busy
);

    state_t          state_q;
    logic            last_grant_q;
    logic [OPW-1:0]  a_q;
    logic [OPW-1:0]  b_q;
    logic [OPW+1:0]  a3_q;
    logic [RESW-1:0] acc_q;
    logic [1:0]      cnt_q;
    logic            id_q;
    logic            rsp_valid_q;
    logic [RESW-1:0] rsp_result_q;
    logic            busy_q;

    logic            grant0_s;
    logic            grant1_s;
    logic [OPW-1:0]  sel_a_s;
    logic [OPW-1:0]  sel_b_s;
    logic [OPW+1:0]  a3_d;
    logic [9:0]      b_ext_s;
    logic [3:0]      grp_s;
    logic [RESW-1:0] pp_s;
    logic [RESW-1:0] pp_shift_s;
    logic [RESW-1:0] acc_d;

    // Round-robin grant, only while idle; on a tie the requester not served last wins.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_q == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0_s = last_grant_q;
                grant1_s = ~last_grant_q;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // Operand mux for the granted requester and its 3A precompute.
    always_comb begin
        if (grant1_s) begin
            sel_a_s = req1_multiplicand;
            sel_b_s = req1_multiplier;
        end else begin
            sel_a_s = req0_multiplicand;
            sel_b_s = req0_multiplier;
        end
        a3_d = {{2{sel_a_s[7]}}, sel_a_s} + {sel_a_s[7], sel_a_s, 1'b0};
    end

    // Current digit's bit group: B extended with b8=b7 on top and b(-1)=0 below.
    always_comb begin
        b_ext_s = {b_q[7], b_q, 1'b0};
        case (cnt_q)
            2'd0:    grp_s = b_ext_s[3:0];
            2'd1:    grp_s = b_ext_s[6:3];
            2'd2:    grp_s = b_ext_s[9:6];
            default: grp_s = 4'd0;
        endcase
    end

    booth3_digit_pp u_digit_pp (
        .grp_i (grp_s),
        .a_i   (a_q),
        .a3_i  (a3_q),
        .pp_o  (pp_s)
    );

    // Weight the partial product by 8^i and fold it into the accumulator.
    always_comb begin
        case (cnt_q)
            2'd0:    pp_shift_s = pp_s;
            2'd1:    pp_shift_s = {pp_s[12:0], 3'b000};
            2'd2:    pp_shift_s = {pp_s[9:0], 6'b000000};
            default: pp_shift_s = 16'd0;
        endcase
        acc_d = acc_q + pp_shift_s;
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_id     = id_q;
    assign busy       = busy_q;

    // Control FSM: accept in IDLE, one digit per cycle in ITER, hold the result in DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            a3_q         <= 10'd0;
            acc_q        <= 16'd0;
            cnt_q        <= 2'd0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 16'd0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant0_s || grant1_s) begin
                        a_q          <= sel_a_s;
                        b_q          <= sel_b_s;
                        a3_q         <= a3_d;
                        id_q         <= grant1_s;
                        last_grant_q <= grant1_s;
                        acc_q        <= 16'd0;
                        cnt_q        <= 2'd0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    acc_q <= acc_d;
                    if (cnt_q == 2'(NDIGITS - 1)) begin
                        cnt_q        <= 2'd0;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= acc_d;
                        state_q      <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        rsp_result_q <= 16'd0;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q  <= 1'b0;
                    rsp_result_q <= 16'd0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth3_mul_arbiter.sv
// Self-checking bench: cycle-level transaction model of the arbiter plus signed-product reference.
module tb_booth3_mul_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req1_valid = 1'b0;
    logic        req0_ready;
    logic        req1_ready;
    logic [7:0]  req0_multiplicand = 8'd0;
    logic [7:0]  req0_multiplier = 8'd0;
    logic [7:0]  req1_multiplicand = 8'd0;
    logic [7:0]  req1_multiplier = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic        busy;

    booth3_mul_arbiter dut (
        .CLK               (CLK),
        .RST               (RST),
        .req0_valid        (req0_valid),
        .req1_valid        (req1_valid),
        .req0_ready        (req0_ready),
        .req1_ready        (req1_ready),
        .req0_multiplicand (req0_multiplicand),
        .req0_multiplier   (req0_multiplier),
        .req1_multiplicand (req1_multiplicand),
        .req1_multiplier   (req1_multiplier),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_id            (rsp_id),
        .rsp_result        (rsp_result),
        .busy              (busy)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: 0 idle, 1..3 digit cycles pending, 4 result held.
    int          m_phase = 0;
    bit          m_last  = 1'b1;
    logic [15:0] m_res   = 16'd0;
    bit          m_id    = 1'b0;
    int          starve0 = 0;
    int          starve1 = 0;
    int          n_done  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int x;
        int y;
        x = $signed(a);
        y = $signed(b);
        return 16'(x * y);
    endfunction

    // One clock cycle: inputs already driven after a negedge; ends at the next negedge.
    task automatic step();
        bit e0;
        bit e1;
        #1;
        e0 = (m_phase == 0) && req0_valid && (!req1_valid || m_last);
        e1 = (m_phase == 0) && req1_valid && (!req0_valid || !m_last);
        check_val("ready0", 32'(req0_ready), 32'(e0));
        check_val("ready1", 32'(req1_ready), 32'(e1));
        check_val("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
        @(posedge CLK);
        if (e0 || e1) begin
            m_id   = e1;
            m_last = e1;
            m_res  = e1 ? ref_mul(req1_multiplicand, req1_multiplier)
                        : ref_mul(req0_multiplicand, req0_multiplier);
            if (e1 && req0_valid) starve0++;
            if (e0 && req1_valid) starve1++;
            if (e0) starve0 = 0;
            if (e1) starve1 = 0;
            check_val("starve0", 32'(starve0 <= 1), 32'd1);
            check_val("starve1", 32'(starve1 <= 1), 32'd1);
            m_phase = 1;
        end else if (m_phase >= 1 && m_phase <= 3) begin
            m_phase++;
        end else if (m_phase == 4 && rsp_ready) begin
            m_phase = 0;
            n_done++;
        end
        @(negedge CLK);
        check_val("busy", 32'(busy), 32'(m_phase != 0));
        check_val("rsp_valid", 32'(rsp_valid), 32'(m_phase == 4));
        check_val("rsp_result", 32'(rsp_result), (m_phase == 4) ? 32'(m_res) : 32'd0);
        if (m_phase == 4) check_val("rsp_id", 32'(rsp_id), 32'(m_id));
    endtask

    // Assert reset mid-cycle and check the outputs clear without any clock edge.
    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        RST = 1'b1;
        #2;
        m_phase = 0;
        m_last  = 1'b1;
        starve0 = 0;
        starve1 = 0;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_result", 32'(rsp_result), 32'd0);
        check_val("rst_id", 32'(rsp_id), 32'd0);
        check_val("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check_val("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic run_one(input string tag, input bit id, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] exp);
        int cyc;
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_multiplicand = a; req1_multiplier = b;
        end else begin
            req0_valid = 1'b1; req0_multiplicand = a; req0_multiplier = b;
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_valid(cyc);
        check_val({tag, "_lat"}, 32'(cyc), 32'd3);
        check_val(tag, 32'(rsp_result), 32'(exp));
        check_val({tag, "_id"}, 32'(rsp_id), 32'(id));
        step();
    endtask

    initial begin
        int   cyc;
        int   soak_cycles;
        int   done0;
        logic [15:0] held;

        do_reset();

        // Single request and corner operands
        run_one("single", 1'b0, 8'h89, 8'h26, 16'hEE56);
        run_one("c_80x80", 1'b0, 8'h80, 8'h80, 16'h4000);
        run_one("c_05xFE", 1'b1, 8'h05, 8'hFE, 16'hFFF6);
        run_one("c_00x7F", 1'b0, 8'h00, 8'h7F, 16'h0000);
        run_one("c_7Fx80", 1'b1, 8'h7F, 8'h80, 16'hC080);

        // Tie right after reset: req0 first, then req1
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_multiplicand = 8'h7A; req0_multiplier = 8'h3F;
        req1_valid = 1'b1; req1_multiplicand = 8'h7A; req1_multiplier = 8'h3F;
        step();
        wait_valid(cyc);
        check_val("tie_first", 32'(rsp_result), 32'h1E06);
        check_val("tie_first_id", 32'(rsp_id), 32'd0);
        step();
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_valid(cyc);
        check_val("tie_second", 32'(rsp_result), 32'h1E06);
        check_val("tie_second_id", 32'(rsp_id), 32'd1);
        step();

        // Backpressure: result held for 5 cycles with requests pending
        req1_valid = 1'b1; req1_multiplicand = 8'hC3; req1_multiplier = 8'h5A;
        rsp_ready = 1'b0;
        step();
        req1_valid = 1'b0;
        wait_valid(cyc);
        held = ref_mul(8'hC3, 8'h5A);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("bp_hold", 32'(rsp_result), 32'(held));
            check_val("bp_id", 32'(rsp_id), 32'd1);
        end
        rsp_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        check_val("bp_retire", 32'(rsp_valid), 32'd0);

        // Reset during the second digit cycle, then a fresh request
        req0_valid = 1'b1; req0_multiplicand = 8'h55; req0_multiplier = 8'hAA;
        step();
        req0_valid = 1'b0;
        step();
        do_reset();
        run_one("after_rst", 1'b0, 8'h3F, 8'h3F, 16'h0F81);

        // Random soak
        done0 = n_done;
        soak_cycles = 0;
        while ((n_done - done0) < 10000 && soak_cycles < 80000) begin
            req0_valid = ($urandom_range(0, 15) != 0);
            req1_valid = ($urandom_range(0, 15) != 0);
            rsp_ready  = ($urandom_range(0, 15) != 0);
            req0_multiplicand = 8'($urandom_range(0, 255));
            req0_multiplier   = 8'($urandom_range(0, 255));
            req1_multiplicand = 8'($urandom_range(0, 255));
            req1_multiplier   = 8'($urandom_range(0, 255));
            step();
            soak_cycles++;
        end
        check_val("soak_ops", 32'(n_done - done0), 32'd10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
